// File: rtl/rsa_pkg.sv
// rsa_pkg: shared word width, config selectors and scheduler state encoding (TIMEOUT only with RSA_TIMEOUT_EN)
package rsa_pkg;
  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;
  localparam logic CFG_SEL_EXP = 1'b0;
  localparam logic CFG_SEL_MOD = 1'b1;
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t CHECK = 3'd1;
  localparam state_t ISSUE = 3'd2;
  localparam state_t WAIT  = 3'd3;
`ifdef RSA_TIMEOUT_EN
  localparam state_t TIMEOUT = 3'd4;
`endif
endpackage

// File: rtl/rsa_job_sched_if.sv
// rsa_job_sched_if: config, message, result and engine signals of the RSA job scheduler
interface rsa_job_sched_if;
  import rsa_pkg::*;
  logic  cfg_we, cfg_sel, cfg_err;
  word_t cfg_wdata;
  logic  in_valid, in_ready;
  word_t in_data;
  logic  out_valid, out_ready, out_err;
  word_t out_data;
  logic  busy;
  logic  exp_start, exp_done, exp_abort;
  word_t exp_base, exp_exponent, exp_modulus, exp_result;
  modport master (
    input  cfg_we, cfg_sel, cfg_wdata, in_valid, in_data, out_ready, exp_result, exp_done,
    output cfg_err, in_ready, out_valid, out_data, out_err, busy,
           exp_start, exp_base, exp_exponent, exp_modulus, exp_abort
  );
  modport slave (
    output cfg_we, cfg_sel, cfg_wdata, in_valid, in_data, out_ready, exp_result, exp_done,
    input  cfg_err, in_ready, out_valid, out_data, out_err, busy,
           exp_start, exp_base, exp_exponent, exp_modulus, exp_abort
  );
endinterface

// File: rtl/rsa_msg_fifo.sv
// rsa_msg_fifo: DEPTH x 16 pointer-based message FIFO with full/empty flags
module rsa_msg_fifo import rsa_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  word_t wdata,
  output word_t rdata,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  word_t mem [DEPTH];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];
  // pointers carry a wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
  // storage needs no reset: the pointers decide what is valid
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/rsa_job_sched.sv
// rsa_job_sched: queues message words and runs one m^e mod n engine job at a time (RSA_TIMEOUT_EN adds a job watchdog)
module rsa_job_sched import rsa_pkg::*; #(
  parameter int DEPTH = 4
`ifdef RSA_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input logic            clk,
  input logic            reset,
  rsa_job_sched_if.master bus
);
  state_t state;
  word_t  e_q, n_q, base_q, head, out_data_q;
  logic   out_valid_q, out_err_q, cfg_err_q;
  logic   full, empty, push, pop, busy, bad, done_ok, fail;
`ifdef RSA_TIMEOUT_EN
  logic [15:0] wd_cnt;
`endif
  assign busy = state != IDLE || !empty;
  assign push = bus.in_valid && !full;
  assign pop = state == IDLE && !empty && (!out_valid_q || bus.out_ready);
  assign bad = n_q < 16'd2 || base_q >= n_q;
  assign done_ok = state == WAIT && bus.exp_done;
`ifdef RSA_TIMEOUT_EN
  assign fail = (state == CHECK && bad) || state == TIMEOUT;
  assign bus.exp_abort = state == TIMEOUT;
`else
  assign fail = state == CHECK && bad;
  assign bus.exp_abort = 1'b0;
`endif
  assign bus.busy = busy;
  assign bus.in_ready = !full;
  assign bus.cfg_err = cfg_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_err = out_err_q;
  assign bus.out_data = out_data_q;
  assign bus.exp_start = state == ISSUE;
  assign bus.exp_base = base_q;
  assign bus.exp_exponent = e_q;
  assign bus.exp_modulus = n_q;
  rsa_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .wdata(bus.in_data), .rdata(head), .full(full), .empty(empty)
  );
  // config writes only land while nothing is queued or in flight; otherwise flag the rejection
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      e_q <= '0;
      n_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we && busy;
      if (bus.cfg_we && !busy && bus.cfg_sel == CFG_SEL_MOD) n_q <= bus.cfg_wdata;
      if (bus.cfg_we && !busy && bus.cfg_sel == CFG_SEL_EXP) e_q <= bus.cfg_wdata;
    end
  // job sequencer: pop, validate operand, start engine, wait for completion
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else
      case (state)
        IDLE:  if (pop) state <= CHECK;
        CHECK: state <= bad ? IDLE : ISSUE;
        ISSUE: state <= WAIT;
        WAIT:
          if (bus.exp_done) state <= IDLE;
`ifdef RSA_TIMEOUT_EN
          else if (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) state <= TIMEOUT;
        TIMEOUT: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
`ifdef RSA_TIMEOUT_EN
  // watchdog counts WAIT cycles of the current job
  always_ff @(posedge clk or posedge reset)
    if (reset) wd_cnt <= '0;
    else wd_cnt <= state == ISSUE ? '0 : state == WAIT ? wd_cnt + 16'd1 : wd_cnt;
`endif
  // engine base is latched at pop and held for the whole job
  always_ff @(posedge clk or posedge reset)
    if (reset) base_q <= '0;
    else if (pop) base_q <= head;
  // result register: a new result wins over a same-cycle consume
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid_q <= 1'b0;
      out_err_q <= 1'b0;
      out_data_q <= '0;
    end else if (done_ok || fail) begin
      out_valid_q <= 1'b1;
      out_err_q <= fail;
      out_data_q <= fail ? '0 : bus.exp_result;
    end else if (bus.out_ready) out_valid_q <= 1'b0;
endmodule

// File: tb/tb_rsa_job_sched.sv
// tb_rsa_job_sched: directed bench for rsa_job_sched with a behavioural exponentiation engine
module tb_rsa_job_sched;
  import rsa_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  rsa_job_sched_if bus();
`ifdef RSA_TIMEOUT_EN
  rsa_job_sched #(.DEPTH(4), .TIMEOUT_CYCLES(50)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  rsa_job_sched #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;
  int total = 0, passed = 0, starts = 0, aborts = 0, cd = 0, lat = 1, s0;
  bit eng_en = 1'b1;
  logic mdl_done = 1'b0, man_done = 1'b0;
  word_t mdl_res = '0, man_res = '0, st_base = '0, st_exp = '0, st_mod = '0;
  assign bus.exp_done = mdl_done | man_done;
  assign bus.exp_result = man_done ? man_res : mdl_res;

  function automatic word_t modexp(word_t b, word_t e, word_t n);
    logic [31:0] r, x;
    r = 1;
    x = 32'(b) % 32'(n);
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % 32'(n);
      x = (x * x) % 32'(n);
    end
    return r[15:0];
  endfunction

  // engine model: sees exp_start at the falling edge, answers lat cycles later
  always @(negedge clk) begin
    if (bus.exp_abort) aborts++;
    if (reset) begin
      cd = 0;
      mdl_done = 1'b0;
    end else if (bus.exp_start) begin
      starts++;
      st_base = bus.exp_base;
      st_exp = bus.exp_exponent;
      st_mod = bus.exp_modulus;
      if (eng_en) begin
        cd = lat;
        mdl_res = modexp(bus.exp_base, bus.exp_exponent, bus.exp_modulus);
      end
      mdl_done = 1'b0;
    end else if (cd > 0) begin
      cd--;
      mdl_done = cd == 0;
    end else mdl_done = 1'b0;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    else passed++;
  endtask

  task automatic cfg(logic sel, word_t d);
    bus.cfg_we = 1'b1;
    bus.cfg_sel = sel;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic push(word_t m);
    chk("push_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data = m;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int k = 0;
    while (!bus.exp_start && k < 50) begin
      tick();
      k++;
    end
    chk("start_seen", bus.exp_start, 1);
  endtask

  task automatic get(string tag, word_t d, logic e, bit consume = 1'b1);
    int k = 0;
    while (!bus.out_valid && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_data"}, bus.out_data, d);
    chk({tag, "_err"}, bus.out_err, e);
    if (consume) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_wdata = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    tick(2);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_exp_start", bus.exp_start, 0);
    chk("rst_modulus", bus.exp_modulus, 0);
    reset = 1'b0;
    tick();
    cfg(CFG_SEL_EXP, 16'd17);
    cfg(CFG_SEL_MOD, 16'd3233);
    chk("cfg_exp", bus.exp_exponent, 17);
    chk("cfg_mod", bus.exp_modulus, 3233);
    chk("cfg_no_err", bus.cfg_err, 0);
    // single job with latency check: pop edge, CHECK, then ISSUE
    s0 = starts;
    push(16'd65);
    tick();
    chk("lat_start_early", bus.exp_start, 0);
    tick();
    chk("lat_start", bus.exp_start, 1);
    get("m65", 16'd2790, 1'b0);
    chk("m65_starts", starts - s0, 1);
    chk("m65_base", st_base, 65);
    chk("m65_exp", st_exp, 17);
    chk("m65_mod", st_mod, 3233);
    // m >= n rejected without touching the engine
    s0 = starts;
    push(16'd3233);
    push(16'd65);
    get("m_eq_n", 16'd0, 1'b1);
    chk("m_eq_n_starts", starts - s0, 0);
    get("after_err", 16'd2790, 1'b0);
    chk("after_err_starts", starts - s0, 1);
    // hold a result and fill the FIFO behind it
    lat = 3;
    push(16'd3233);
    get("held", 16'd0, 1'b1, 1'b0);
    s0 = starts;
    push(16'd65);
    push(16'd0);
    push(16'd1);
    push(16'd3232);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_busy", bus.busy, 1);
    tick(5);
    chk("held_no_start", starts - s0, 0);
    get("held2", 16'd0, 1'b1);
    get("f65", 16'd2790, 1'b0);
    get("f0", 16'd0, 1'b0);
    get("f1", 16'd1, 1'b0);
    get("f3232", 16'd3232, 1'b0);
    chk("fill_starts", starts - s0, 4);
    // config write rejected while a job waits on the engine
    lat = 20;
    push(16'd65);
    wait_start();
    tick();
    cfg(CFG_SEL_EXP, 16'd5);
    chk("cfg_err_pulse", bus.cfg_err, 1);
    chk("cfg_err_exp_kept", bus.exp_exponent, 17);
    tick();
    chk("cfg_err_clear", bus.cfg_err, 0);
    get("cfg_wait", 16'd2790, 1'b0);
    // modulus below 2 rejects every word
    lat = 1;
    cfg(CFG_SEL_MOD, 16'd1);
    chk("n1_mod", bus.exp_modulus, 1);
    s0 = starts;
    push(16'd0);
    get("n1", 16'd0, 1'b1);
    chk("n1_starts", starts - s0, 0);
    cfg(CFG_SEL_MOD, 16'd3233);
    // reset while waiting drops everything
    eng_en = 1'b0;
    push(16'd65);
    push(16'd1);
    wait_start();
    tick();
    reset = 1'b1;
    #1;
    chk("rstw_out_valid", bus.out_valid, 0);
    chk("rstw_busy", bus.busy, 0);
    chk("rstw_in_ready", bus.in_ready, 1);
    chk("rstw_exp", bus.exp_exponent, 0);
    tick();
    reset = 1'b0;
    s0 = starts;
    man_res = 16'd2790;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick(5);
    chk("late_done_valid", bus.out_valid, 0);
    chk("late_done_busy", bus.busy, 0);
    chk("late_done_starts", starts - s0, 0);
    // engine that never answers
    cfg(CFG_SEL_EXP, 16'd17);
    cfg(CFG_SEL_MOD, 16'd3233);
    s0 = aborts;
    push(16'd65);
    wait_start();
    tick(100);
`ifdef RSA_TIMEOUT_EN
    chk("wd_abort", aborts - s0, 1);
    get("wd", 16'd0, 1'b1);
    chk("wd_idle", bus.busy, 0);
`else
    chk("nowd_abort", aborts - s0, 0);
    chk("nowd_busy", bus.busy, 1);
    chk("nowd_valid", bus.out_valid, 0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    get("nowd", 16'd2790, 1'b0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
